// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, drives a single-outstanding imem request/response port, presents pcF/instF to IF/ID.
// First validF two cycles after the accept; stallF holds the presented instruction, imem_ready low holds the request.
module if_fetch_stage #(
    parameter int                      ADDR_WIDTH = 32,
    parameter int                      INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = 32'h0000_0000,
    parameter logic [INST_WIDTH-1:0]   NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallF,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0] pcF,
    output logic [ADDR_WIDTH-1:0] pcplus4F,
    output logic [INST_WIDTH-1:0] instF,
    output logic                  validF
);

    typedef enum logic [1:0] {
        S_ISSUE   = 2'd0,
        S_WAIT    = 2'd1,
        S_DELIVER = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic                  r_drop;
    logic                  w_drop_nxt;
    logic [INST_WIDTH-1:0] r_inst_buf;
    logic [INST_WIDTH-1:0] w_inst_nxt;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_redir_pc;

    assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);
    assign w_redir_pc = redirect_pc & ~ADDR_WIDTH'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_ISSUE;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_inst_buf <= NOP_INST;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_drop     <= w_drop_nxt;
            r_inst_buf <= w_inst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_inst_nxt  = r_inst_buf;
        imem_req    = 1'b0;
        imem_addr   = r_pc;
        validF      = 1'b0;
        case (r_state)
            S_ISSUE: begin
                imem_req = !redirect_valid;
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                end else if (imem_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt   = w_redir_pc;
                    w_drop_nxt = 1'b1;
                end
                // A redirect landing with the response kills it just like a pending drop.
                if (imem_rvalid) begin
                    if (r_drop || redirect_valid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_inst_nxt  = imem_rdata;
                        w_state_nxt = S_DELIVER;
                    end
                end
            end
            S_DELIVER: begin
                validF = !redirect_valid;
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_ISSUE;
                end else if (!stallF) begin
                    imem_req    = 1'b1;
                    imem_addr   = w_pc_plus4;
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = imem_ready ? S_WAIT : S_ISSUE;
                end
            end
            default: begin
                w_state_nxt = S_ISSUE;
            end
        endcase
        if (rst) begin
            imem_req = 1'b0;
            validF   = 1'b0;
        end
    end

    assign pcF      = r_pc;
    assign pcplus4F = w_pc_plus4;
    assign instF    = validF ? r_inst_buf : NOP_INST;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Random-stimulus bench for if_fetch_stage: memory model with random ready/latency, scoreboard of expected fetch PCs.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallF = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pcF;
    logic [31:0] pcplus4F;
    logic [31:0] instF;
    logic        validF;

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stallF         (stallF),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .pcF            (pcF),
        .pcplus4F       (pcplus4F),
        .instF          (instF),
        .validF         (validF)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC001_D00D;
    endfunction

    // Each entry re-targets the expected fetch stream (redirects and resets).
    logic [31:0] redir_q[$];
    bit          directed = 1'b1;
    bit          done = 1'b0;

    // Handshake observation for the memory model.
    bit          acc_seen = 1'b0;
    logic [31:0] acc_addr = 32'h0;

    always @(negedge clk) begin
        acc_seen = !rst && imem_req && imem_ready;
        acc_addr = imem_addr;
    end

    // ---------------- stimulus and memory model ----------------
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;

    task automatic drive(input bit rst_v, input bit stall_v, input bit redir_v,
                         input logic [31:0] rpc, input bit ready_v, input int lat);
        @(posedge clk);
        #1;
        rst            = rst_v;
        stallF         = stall_v;
        redirect_valid = redir_v;
        redirect_pc    = rpc;
        imem_ready     = ready_v;
        imem_rvalid    = 1'b0;
        imem_rdata     = $urandom;
        if (rst_v) begin
            pend = 1'b0;
        end else begin
            if (acc_seen && !pend) begin
                pend  = 1'b1;
                paddr = acc_addr;
                cnt   = lat;
            end
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_data(paddr);
                    pend        = 1'b0;
                end
            end
        end
        if (rst_v)
            redir_q.push_back(RESET_PC);
        else if (redir_v)
            redir_q.push_back(rpc & ~32'd3);
    endtask

    initial begin
        logic [31:0] rpc;
        bit          r_v;
        bit          d_v;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        for (int i = 0; i < 12; i++)
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        directed = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r_v = ($urandom_range(0, 199) == 0);
            d_v = !r_v && ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFFC;
                1:       rpc = 32'h0000_0103;
                default: rpc = $urandom;
            endcase
            drive(r_v, $urandom_range(0, 99) < 30, d_v, rpc,
                  $urandom_range(0, 99) < 60, $urandom_range(1, 3));
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1);
        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL end_of_test: monitor did not finish, got running required finished");
        $fatal(1);
    end

    // ---------------- monitor / scoreboard ----------------
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] m_pc = RESET_PC;
    int          since_rst = 0;
    int          n_deliv = 0;
    bit          first_seen = 1'b0;
    bit          prev_rst = 1'b1;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        while (redir_q.size() > 0)
            m_pc = redir_q.pop_front();
        if (rst) begin
            check("reset_req", 32'(imem_req), 32'd0);
            check("reset_valid", 32'(validF), 32'd0);
            check("reset_inst", instF, NOP);
            since_rst  = 0;
            first_seen = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (prev_rst)
                check("pc_after_reset", pcF, RESET_PC);
            if (prev_hold && !redirect_valid) begin
                check("req_held", 32'(imem_req), 32'd1);
                check("addr_held", imem_addr, prev_addr);
            end
            if (directed && !first_seen) begin
                if (validF || since_rst > 8) begin
                    first_seen = 1'b1;
                    check("first_valid_cycle", 32'(since_rst), 32'd2);
                end
            end
            if (imem_req)
                check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
            if (validF) begin
                if (stallF) begin
                    check("req_in_stall", 32'(imem_req), 32'd0);
                end else begin
                    check("pcF", pcF, m_pc);
                    check("pcplus4F", pcplus4F, m_pc + 32'd4);
                    check("instF", instF, mem_data(m_pc));
                    check("fast_req", 32'(imem_req), 32'd1);
                    check("fast_addr", imem_addr, m_pc + 32'd4);
                    if (directed)
                        check("zero_wait_cadence", 32'(since_rst % 2), 32'd0);
                    m_pc = m_pc + 32'd4;
                    n_deliv++;
                end
            end else begin
                check("nop_when_invalid", instF, NOP);
            end
            since_rst++;
            prev_hold = imem_req && !imem_ready;
            prev_addr = imem_addr;
        end
        prev_rst = rst;
        if (done) begin
            check("enough_deliveries", 32'(n_deliv >= 150), 32'd1);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
        end
    end

endmodule
